// File: rtl/mips_perf_pkg.sv
// Shared types, opcode constants and instruction-class decode for the
// multicycle MIPS performance monitor.
package mips_perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } mon_state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_OTHER  = 3'd5
    } inst_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam int NUM_CLASSES  = 6;
    // cycle + instruction counters followed by one counter per class
    localparam int NUM_COUNTERS = 2 + NUM_CLASSES;

    localparam logic [3:0] RD_SEL_CYCLE  = 4'd0;
    localparam logic [3:0] RD_SEL_INSTR  = 4'd1;
    localparam logic [3:0] RD_SEL_R      = 4'd2;
    localparam logic [3:0] RD_SEL_LOAD   = 4'd3;
    localparam logic [3:0] RD_SEL_STORE  = 4'd4;
    localparam logic [3:0] RD_SEL_BRANCH = 4'd5;
    localparam logic [3:0] RD_SEL_JUMP   = 4'd6;
    localparam logic [3:0] RD_SEL_OTHER  = 4'd7;

    // Map an opcode onto the class whose counter it increments.
    function automatic inst_class_e decode_class(input logic [5:0] op);
        inst_class_e cls;
        case (op)
            OP_RTYPE:       cls = CLS_R;
            OP_LW:          cls = CLS_LOAD;
            OP_SW:          cls = CLS_STORE;
            OP_BEQ, OP_BNE: cls = CLS_BRANCH;
            OP_J, OP_JAL:   cls = CLS_JUMP;
            default:        cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; sticks at all-ones.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc unless already saturated; rst beats clr beats inc.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt <= {CNT_W{1'b0}};
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mips_perf_monitor.sv
// Performance/trace monitor for the multicycle MIPS core: counts cycles,
// fetches and per-class executes, detects the jump-to-self end of program
// and enforces a cycle-budget watchdog. Counters are read via rd_sel.
module mips_perf_monitor
    import mips_perf_pkg::*;
#(
    parameter int                 CNT_W      = 32,
    parameter int                 MAX_CYCLES = 500,
    parameter int                 STATE_W    = 4,
    parameter logic [STATE_W-1:0] FETCH_ST   = 4'b0000,
    parameter logic [STATE_W-1:0] EX_ST      = 4'b0010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [STATE_W-1:0] S,
    input  logic [31:0]        inst,
    input  logic [31:0]        addr,
    input  logic [3:0]         rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [1:0]         mon_st,
    output logic               halted,
    output logic               timeout
);

    localparam logic [63:0] MAX_CYCLES_W = 64'(MAX_CYCLES);

    mon_state_e                 state_r;
    logic [31:0]                fetch_pc_r;
    logic [CNT_W-1:0]           cnt_s [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]    inc_s;
    logic [NUM_CLASSES-1:0]     cls_onehot_s;
    logic [5:0]                 op_s;
    inst_class_e                cls_s;
    logic                       is_fetch_s;
    logic                       is_ex_s;
    logic                       count_s;
    logic                       halt_s;
    logic                       wd_hit_s;
    logic [CNT_W-1:0]           cycle_next_s;
    logic                       unused_pc_bits_s;

    // Only PC[27:2] takes part in the jump-target compare.
    assign unused_pc_bits_s = ^{fetch_pc_r[31:28], fetch_pc_r[1:0]};

    // Decode the current cycle: is it counted, which counters step, halt/watchdog hits.
    always_comb begin
        op_s       = inst[31:26];
        cls_s      = decode_class(op_s);
        is_fetch_s = (S == FETCH_ST);
        is_ex_s    = (S == EX_ST);

        // The IDLE->RUN entry cycle already counts.
        if (state_r == RUN) begin
            count_s = en;
        end else if (state_r == IDLE) begin
            count_s = en & is_fetch_s;
        end else begin
            count_s = 1'b0;
        end

        halt_s = count_s & (state_r == RUN) & is_ex_s & (op_s == OP_J)
               & (inst[25:0] == fetch_pc_r[27:2]);

        // Watchdog looks at the cycle count as it will be after this edge.
        if (cnt_s[0] == {CNT_W{1'b1}}) begin
            cycle_next_s = cnt_s[0];
        end else begin
            cycle_next_s = cnt_s[0] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        wd_hit_s = (MAX_CYCLES != 32'sd0) && (64'(cycle_next_s) == MAX_CYCLES_W);

        cls_onehot_s = {{(NUM_CLASSES-1){1'b0}}, 1'b1} << cls_s;
        inc_s[0]     = count_s;
        inc_s[1]     = count_s & is_fetch_s;
        inc_s[NUM_COUNTERS-1:2] = {NUM_CLASSES{count_s & is_ex_s}} & cls_onehot_s;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
            perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (clr),
                .inc (inc_s[g]),
                .cnt (cnt_s[g])
            );
        end
    endgenerate

    // Remember the PC of the last counted fetch for the jump-to-self check.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= 32'd0;
        end else if (clr) begin
            fetch_pc_r <= 32'd0;
        end else if (count_s && is_fetch_s) begin
            fetch_pc_r <= addr;
        end
    end

    // Monitor FSM with registered halted/timeout flags; halt wins over watchdog.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_r <= IDLE;
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_s) begin
                        if (wd_hit_s) begin
                            state_r <= TIMEOUT;
                            timeout <= 1'b1;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (halt_s) begin
                        state_r <= HALTED;
                        halted  <= 1'b1;
                    end else if (count_s && wd_hit_s) begin
                        state_r <= TIMEOUT;
                        timeout <= 1'b1;
                    end
                end
                HALTED, TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= IDLE;
                    halted  <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

    assign mon_st = state_r;

    // Registered readout of the selected counter (pre-update value); selects 8..15 read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {CNT_W{1'b0}};
        end else if (rd_sel[3] == 1'b0) begin
            rd_data <= cnt_s[rd_sel[2:0]];
        end else begin
            rd_data <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mips_perf_monitor.sv
// Self-checking bench: three monitor instances (default, 20-cycle watchdog,
// 4-bit counters) share one stimulus stream and are compared every cycle
// against a behavioural model, plus directed vectors with fixed expectations.
module tb_mips_perf_monitor;

    localparam logic [31:0] ADD_I = 32'h0022_1820;
    localparam logic [31:0] LW_I  = 32'h8C22_0004;
    localparam logic [31:0] SW_I  = 32'hAC22_0008;
    localparam logic [31:0] BEQ_I = 32'h1022_0002;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [3:0]  S, rd_sel;
    logic [31:0] inst, addr;

    logic [31:0] rd_main, rd_wd;
    logic [3:0]  rd_sat;
    logic [1:0]  st_main, st_wd, st_sat;
    logic        h_main, h_wd, h_sat, t_main, t_wd, t_sat;

    int checks   = 0;
    int failures = 0;

    // Model: 0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT; counters 0 cycle,1 instr,2..7 classes
    longint unsigned mcnt [3][8];
    longint unsigned mmax [3];
    longint unsigned mrd  [3];
    int              mwd  [3];
    int              mst  [3];
    logic [31:0]     mpc  [3];

    always #5 clk = ~clk;

    mips_perf_monitor u_main (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .inst(inst), .addr(addr),
        .rd_sel(rd_sel), .rd_data(rd_main), .mon_st(st_main), .halted(h_main), .timeout(t_main)
    );

    mips_perf_monitor #(.MAX_CYCLES(20)) u_wd (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .inst(inst), .addr(addr),
        .rd_sel(rd_sel), .rd_data(rd_wd), .mon_st(st_wd), .halted(h_wd), .timeout(t_wd)
    );

    mips_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .S(S), .inst(inst), .addr(addr),
        .rd_sel(rd_sel), .rd_data(rd_sat), .mon_st(st_sat), .halted(h_sat), .timeout(t_sat)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'h00:        return 2;
            6'h23:        return 3;
            6'h2B:        return 4;
            6'h04, 6'h05: return 5;
            6'h02, 6'h03: return 6;
            default:      return 7;
        endcase
    endfunction

    function automatic longint unsigned sat_inc(input int k, input longint unsigned v);
        return (v >= mmax[k]) ? mmax[k] : v + 1;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit halt;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int j = 0; j < 8; j++) mcnt[k][j] = 0;
                mst[k] = 0; mrd[k] = 0; mpc[k] = 32'd0;
            end else begin
                mrd[k] = (rd_sel < 4'd8) ? mcnt[k][rd_sel[2:0]] : 0;
                if (clr) begin
                    for (int j = 0; j < 8; j++) mcnt[k][j] = 0;
                    mst[k] = 0; mpc[k] = 32'd0;
                end else if (en && (mst[k] == 1 || (mst[k] == 0 && S == 4'd0))) begin
                    halt = (mst[k] == 1) && (S == 4'd2) && (inst[31:26] == 6'h02)
                           && (inst[25:0] == mpc[k][27:2]);
                    mcnt[k][0] = sat_inc(k, mcnt[k][0]);
                    if (S == 4'd0) begin
                        mcnt[k][1] = sat_inc(k, mcnt[k][1]);
                        mpc[k] = addr;
                    end
                    if (S == 4'd2) mcnt[k][cls_of(inst[31:26])] = sat_inc(k, mcnt[k][cls_of(inst[31:26])]);
                    if (halt) mst[k] = 2;
                    else if (mwd[k] != 0 && mcnt[k][0] == longint'(mwd[k])) mst[k] = 3;
                    else mst[k] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] ar [3];
        logic [63:0] as [3];
        logic        ah [3];
        logic        at [3];
        ar[0] = 64'(rd_main); ar[1] = 64'(rd_wd); ar[2] = 64'(rd_sat);
        as[0] = 64'(st_main); as[1] = 64'(st_wd); as[2] = 64'(st_sat);
        ah[0] = h_main; ah[1] = h_wd; ah[2] = h_sat;
        at[0] = t_main; at[1] = t_wd; at[2] = t_sat;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("model_rd_data_%0d", k), ar[k], mrd[k]);
            check($sformatf("model_mon_st_%0d", k), as[k], 64'(mst[k]));
            check($sformatf("model_halted_%0d", k), 64'(ah[k]), 64'(mst[k] == 2));
            check($sformatf("model_timeout_%0d", k), 64'(at[k]), 64'(mst[k] == 3));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_instr(input logic [31:0] i, input logic [31:0] a);
        for (int s = 0; s < 4; s++) begin
            en = 1'b1; inst = i; addr = a; S = 4'(s);
            tick();
        end
    endtask

    task automatic rd_expect(input string name, input int k, input logic [3:0] sel,
                             input logic [63:0] exp);
        en = 1'b0; rd_sel = sel;
        tick();
        case (k)
            0:       check(name, 64'(rd_main), exp);
            1:       check(name, 64'(rd_wd), exp);
            default: check(name, 64'(rd_sat), exp);
        endcase
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  s;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [1:0]  exp_st;
    } vec_t;

    vec_t vecs [8];

    initial begin
        mmax[0] = 64'hFFFF_FFFF; mmax[1] = 64'hFFFF_FFFF; mmax[2] = 64'd15;
        mwd[0] = 500; mwd[1] = 20; mwd[2] = 0;
        vecs[0] = '{1'b1, 4'd0, 4'd0, 32'd0, 2'd1};
        vecs[1] = '{1'b1, 4'd1, 4'd1, 32'd1, 2'd1};
        vecs[2] = '{1'b1, 4'd2, 4'd0, 32'd2, 2'd1};
        vecs[3] = '{1'b1, 4'd3, 4'd2, 32'd1, 2'd1};
        vecs[4] = '{1'b0, 4'd0, 4'd0, 32'd4, 2'd1};
        vecs[5] = '{1'b0, 4'd0, 4'd1, 32'd1, 2'd1};
        vecs[6] = '{1'b0, 4'd0, 4'd2, 32'd1, 2'd1};
        vecs[7] = '{1'b0, 4'd0, 4'd9, 32'd0, 2'd1};

        rst = 1'b1; en = 1'b0; clr = 1'b0; S = 4'd0; rd_sel = 4'd0;
        inst = ADD_I; addr = 32'd0;
        tick(); tick();
        check("reset_rd_data", 64'(rd_main), 64'd0);
        check("reset_mon_st", 64'(st_main), 64'd0);
        check("reset_flags", 64'({h_main, t_main}), 64'd0);
        rst = 1'b0;

        // One add through IF/ID/EX/WB, then frozen readout
        inst = ADD_I; addr = 32'd0;
        for (int i = 0; i < 8; i++) begin
            en = vecs[i].en; S = vecs[i].s; rd_sel = vecs[i].sel;
            tick();
            check($sformatf("vec%0d_rd_data", i), 64'(rd_main), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_mon_st", i), 64'(st_main), 64'(vecs[i].exp_st));
        end

        // lw, sw, beq, then j-to-self at 0x90
        clr = 1'b1; tick(); clr = 1'b0;
        run_instr(LW_I, 32'h84);
        run_instr(SW_I, 32'h88);
        run_instr(BEQ_I, 32'h8C);
        en = 1'b1; inst = 32'h0800_0024; addr = 32'h90;
        S = 4'd0; tick();
        S = 4'd1; tick();
        check("halt_before_ex", 64'(h_main), 64'd0);
        S = 4'd2; tick();
        check("halt_after_ex", 64'(h_main), 64'd1);
        check("halt_mon_st", 64'(st_main), 64'd2);
        S = 4'd3; tick();
        run_instr(ADD_I, 32'h94);
        run_instr(LW_I, 32'h98);
        rd_expect("prog_cycle", 0, 4'd0, 64'd15);
        rd_expect("prog_instr", 0, 4'd1, 64'd4);
        rd_expect("prog_r", 0, 4'd2, 64'd0);
        rd_expect("prog_load", 0, 4'd3, 64'd1);
        rd_expect("prog_store", 0, 4'd4, 64'd1);
        rd_expect("prog_branch", 0, 4'd5, 64'd1);
        rd_expect("prog_jump", 0, 4'd6, 64'd1);
        rd_expect("prog_other", 0, 4'd7, 64'd0);

        // rst while HALTED
        rd_sel = 4'd0; rst = 1'b1; tick(); rst = 1'b0;
        check("rst_halted_flag", 64'(h_main), 64'd0);
        check("rst_halted_rd", 64'(rd_main), 64'd0);
        check("rst_halted_st", 64'(st_main), 64'd0);

        // Watchdog at 20 cycles on the non-halting loop; CNT_W=4 saturates at 15
        for (int i = 0; i < 4; i++) run_instr(ADD_I, 32'h100 + 32'(4 * i));
        en = 1'b1; addr = 32'h110;
        S = 4'd0; tick(); S = 4'd1; tick(); S = 4'd2; tick();
        check("wd_before", 64'(t_wd), 64'd0);
        S = 4'd3; tick();
        check("wd_timeout", 64'(t_wd), 64'd1);
        check("wd_not_halted", 64'(h_wd), 64'd0);
        check("wd_mon_st", 64'(st_wd), 64'd3);
        rd_expect("wd_cycle", 1, 4'd0, 64'd20);
        rd_expect("sat_cycle", 2, 4'd0, 64'd15);
        rd_expect("sat_sel9", 2, 4'd9, 64'd0);
        run_instr(ADD_I, 32'h114);
        run_instr(ADD_I, 32'h118);
        rd_expect("wd_cycle_frozen", 1, 4'd0, 64'd20);
        rd_expect("main_cycle_running", 0, 4'd0, 64'd28);

        // Halt EX lands on the 20th counted cycle
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 4; i++) run_instr(ADD_I, 32'h0 + 32'(4 * i));
        en = 1'b1; inst = 32'h0800_0010; addr = 32'h40;
        S = 4'd0; tick(); S = 4'd1; tick(); S = 4'd1; tick(); S = 4'd2; tick();
        check("tie_halted", 64'(h_wd), 64'd1);
        check("tie_timeout", 64'(t_wd), 64'd0);
        check("tie_mon_st", 64'(st_wd), 64'd2);

        // clr mid-RUN
        clr = 1'b1; tick(); clr = 1'b0;
        run_instr(ADD_I, 32'h0);
        run_instr(ADD_I, 32'h4);
        en = 1'b1; S = 4'd0; addr = 32'h8; tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_mon_st", 64'(st_main), 64'd0);
        rd_expect("clr_cycle", 0, 4'd0, 64'd0);
        rd_expect("clr_instr", 0, 4'd1, 64'd0);
        rd_expect("clr_r", 0, 4'd2, 64'd0);

        // en low for 5 cycles holds everything
        run_instr(ADD_I, 32'h0);
        run_instr(ADD_I, 32'h4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            S = 4'(i % 4); tick();
        end
        rd_expect("hold_cycle", 0, 4'd0, 64'd8);
        rd_expect("hold_instr", 0, 4'd1, 64'd2);
        rd_expect("hold_r", 0, 4'd2, 64'd2);

        // Randomized stream against the model
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            logic [5:0] ops [8];
            ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
            ops[4] = 6'h05; ops[5] = 6'h02; ops[6] = 6'h03; ops[7] = 6'h0F;
            rst    = ($urandom_range(0, 199) == 0);
            clr    = ($urandom_range(0, 59) == 0);
            en     = ($urandom_range(0, 9) != 0);
            S      = 4'($urandom_range(0, 4));
            rd_sel = 4'($urandom_range(0, 15));
            addr   = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            op     = ops[$urandom_range(0, 7)];
            if (op == 6'h02 && $urandom_range(0, 1) == 0)
                inst = {op, mpc[0][27:2]};
            else
                inst = {op, 26'($urandom())};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
